uart: RTL and testbench
=======================

// Module: uart
// PURPOSE
//  8N1 UART: one transmitter and one receiver sharing a baud-tick generator.
//  Sits between a byte-wide host interface and the serial tx/rx pins.
//  Tx and rx are independent, so tx may loop back to rx.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency in Hz
//  BAUD     115_200     line rate in bit/s
// PORTS
//  clk_50m  in   1  system clock; the only clock
//  rst_n    in   1  reset, asynchronous assert, active-low
//  din      in   8  byte to transmit; sampled on an accepted wr_en
//  wr_en    in   1  1-cycle strobe: start transmitting din
//  tx       out  1  serial output; idle high
//  tx_busy  out  1  high while a frame is being sent
//  rx       in   1  serial input; asynchronous to clk_50m
//  rdy      out  1  sticky flag: dout holds a new received byte
//  rdy_clr  in   1  clears rdy
//  dout     out  8  last received byte
// BEHAVIOUR
//  - Reset values: tx=1, tx_busy=0, rdy=0, dout=8'h00. Both FSMs go to IDLE and all counters clear.
//  - Baud ticks: TX_DIV=round(CLK_HZ/BAUD)=434; RX_DIV=round(CLK_HZ/(16*BAUD))=27.
//    Counter widths use $clog2. Each tick is a 1-cycle pulse.
//  - Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
//  - TX FSM: IDLE -> START -> DATA(x8) -> STOP -> IDLE.
//    - wr_en in IDLE latches din. tx_busy rises on the next clock.
//    - The tx divider restarts on accept, so every bit lasts exactly TX_DIV cycles.
//    - wr_en while tx_busy=1 is ignored; the frame in progress is unaffected.
//    - tx_busy falls in the cycle after the stop bit completes. wr_en is accepted in that same cycle.
//  - RX path:
//    - rx passes through a 2-flop synchronizer before any use.
//    - FSM: IDLE -> START -> DATA -> STOP -> IDLE, clocked by the 16x tick, with a 4-bit sample counter.
//    - IDLE: a synchronized low moves to START.
//    - START: re-check at sample 8. If rx is high, treat it as a false start and return to IDLE.
//    - DATA: sample each bit at the mid-bit point (16 ticks apart) and shift it in LSB first.
//    - STOP: at the stop-bit midpoint, dout <= shift register and rdy <= 1 for that cycle onward.
//    - Then return to IDLE, so the receiver is ready for a back-to-back start bit.
//  - rdy stays high until rdy_clr=1. If rdy_clr and a new byte completion occur in the same cycle, set wins.
//  - A new byte overwrites dout even if rdy is still set (no overrun flag).
//  - rst_n low mid-frame aborts both FSMs immediately. tx returns to 1 asynchronously.
// CONFIGURATION
//  `UART_FRAME_ERR_EN defined:
//    - Adds output frame_err (1 bit, reset 0).
//    - When the sampled stop bit is 0: dout is still updated, rdy is NOT set, frame_err pulses high for 1 cycle.
//  Not defined:
//    - No frame_err port.
//    - The stop bit value is ignored; rdy is always set on frame completion.
// STRUCTURE
//  - Package uart_pkg holds:
//    - tx_state_t and rx_state_t enums {IDLE, START, DATA, STOP}
//    - the DATA_BITS=8 constant
//    - functions computing TX_DIV and RX_DIV from CLK_HZ and BAUD
//  - One sub-module: uart_baud_gen, which produces tx_tick and rx_tick (16x). It takes a tx restart input.
//  - The TX and RX FSMs stay inline in uart.
// TESTING
//  - Loopback tx->rx, send 8'h00..8'hFF, each after rdy then rdy_clr -> every dout equals the byte sent; rdy deasserts after rdy_clr.
//  - Send 8'hA5, sample tx at bit centres -> 0,1,0,1,0,0,1,0,1,1.
//    tx_busy high for 10*434 cycles ±1.
//  - wr_en pulses with 8'h3C while busy sending 8'hC3 -> only 8'hC3 appears on tx; busy period is unchanged.
//  - 5-cycle low glitch on idle rx -> no rdy, and the next valid frame 8'h5A is received correctly.
//  - rst_n low in mid-frame -> tx=1, tx_busy=0, rdy=0 immediately; the next 8'h81 transfer is correct.
//  - rdy_clr asserted in the cycle a new byte completes -> rdy=1.
//  - With UART_FRAME_ERR_EN, drive a stop bit of 0 -> frame_err pulses and rdy stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart slice.
//   tx_state_t / rx_state_t : IDLE, START, DATA, STOP for each FSM
//   DATA_BITS               : payload bits per 8N1 frame
//   calc_tx_div             : round(clk_hz / baud), clocks per bit
//   calc_rx_div             : round(clk_hz / (16 * baud)), clocks per 16x sample tick
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic int unsigned calc_tx_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int unsigned calc_rx_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + 8 * baud) / (16 * baud);
    endfunction

endpackage

// File: rtl/uart_if.sv
// Byte-wide host interface of the uart.
//   din[7:0]  host -> uart  byte to transmit
//   wr_en     host -> uart  1-cycle transmit strobe
//   tx_busy   uart -> host  frame in progress
//   rdy       uart -> host  sticky "new byte in dout"
//   rdy_clr   host -> uart  clears rdy
//   dout[7:0] uart -> host  last received byte
//   frame_err uart -> host  1-cycle bad-stop-bit pulse (only with UART_FRAME_ERR_EN)
// master = host side, slave = uart side.
interface uart_if;

    logic [7:0] din;
    logic       wr_en;
    logic       tx_busy;
    logic       rdy;
    logic       rdy_clr;
    logic [7:0] dout;
`ifdef UART_FRAME_ERR_EN
    logic       frame_err;

    modport master (output din, wr_en, rdy_clr, input tx_busy, rdy, dout, frame_err);
    modport slave  (input din, wr_en, rdy_clr, output tx_busy, rdy, dout, frame_err);
`else
    modport master (output din, wr_en, rdy_clr, input tx_busy, rdy, dout);
    modport slave  (input din, wr_en, rdy_clr, output tx_busy, rdy, dout);
`endif

endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator shared by the uart transmitter and receiver.
//   clk_50m    in  system clock
//   rst_n      in  asynchronous active-low reset
//   tx_restart in  restarts the bit-rate divider (frame accept)
//   tx_tick    out 1-cycle pulse every TX_DIV clocks since the last restart
//   rx_tick    out 1-cycle pulse every RX_DIV clocks (16x oversampling), free running
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic tx_restart,
    output logic tx_tick,
    output logic rx_tick
);

    localparam int unsigned TX_DIV = calc_tx_div(CLK_HZ, BAUD);
    localparam int unsigned RX_DIV = calc_rx_div(CLK_HZ, BAUD);
    localparam int unsigned TX_W   = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam int unsigned RX_W   = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(TX_DIV - 1);
    localparam logic [RX_W-1:0] RX_LAST = RX_W'(RX_DIV - 1);

    logic [TX_W-1:0] tx_cnt;
    logic [RX_W-1:0] rx_cnt;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt <= '0;
        end else if (tx_restart || tx_cnt == TX_LAST) begin
            tx_cnt <= '0;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt <= '0;
        end else if (rx_cnt == RX_LAST) begin
            rx_cnt <= '0;
        end else begin
            rx_cnt <= rx_cnt + 1'b1;
        end
    end

    // A restart in the same cycle suppresses the tick so the new first bit gets a full period.
    assign tx_tick = (tx_cnt == TX_LAST) && !tx_restart;
    assign rx_tick = (rx_cnt == RX_LAST);

endmodule

// File: rtl/uart.sv
// 8N1 UART: transmitter and 16x-oversampling receiver sharing one baud generator.
//   clk_50m  in   system clock (only clock)
//   rst_n    in   asynchronous active-low reset
//   host     --   uart_if.slave: din, wr_en, tx_busy, rdy, rdy_clr, dout (+ frame_err)
//   tx       out  serial output, idle high
//   rx       in   serial input, asynchronous to clk_50m
// Build option: define UART_FRAME_ERR_EN to add frame_err and suppress rdy on a bad stop bit.
module uart
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic    clk_50m,
    input  logic    rst_n,
    uart_if.slave   host,
    output logic    tx,
    input  logic    rx
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic tx_tick, rx_tick, tx_accept;

    uart_baud_gen #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_baud (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .tx_restart (tx_accept),
        .tx_tick    (tx_tick),
        .rx_tick    (rx_tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t  tx_state, tx_state_n;
    logic [7:0] tx_shift, tx_shift_n;
    logic [2:0] tx_bit, tx_bit_n;
    logic       tx_n;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_shift <= tx_shift_n;
            tx_bit   <= tx_bit_n;
            tx       <= tx_n;
        end
    end

    // tx is registered: each line level is loaded on the tick that ends the previous bit.
    always_comb begin
        tx_state_n = tx_state;
        tx_shift_n = tx_shift;
        tx_bit_n   = tx_bit;
        tx_n       = tx;
        tx_accept  = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_n = 1'b1;
                if (host.wr_en) begin
                    tx_accept  = 1'b1;
                    tx_shift_n = host.din;
                    tx_bit_n   = '0;
                    tx_n       = 1'b0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_n       = tx_shift[0];
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bit == LAST_BIT) begin
                        tx_n       = 1'b1;
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_n       = tx_shift[0];
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_bit_n   = tx_bit + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_state_n = TX_IDLE;
                end
            end
        endcase
    end

    assign host.tx_busy = (tx_state != TX_IDLE);

    // ---------------- receiver ----------------
    logic       rx_meta, rx_s;
    rx_state_t  rx_state, rx_state_n;
    logic [3:0] rx_cnt, rx_cnt_n;
    logic [2:0] rx_bit, rx_bit_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic       rx_load, rx_done;
    logic [7:0] dout_q;
    logic       rdy_q;
`ifdef UART_FRAME_ERR_EN
    logic       rx_ferr, ferr_q;
`endif

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_load    = 1'b0;
        rx_done    = 1'b0;
`ifdef UART_FRAME_ERR_EN
        rx_ferr    = 1'b0;
`endif
        if (rx_tick) begin
            unique case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_cnt_n   = '0;
                        rx_state_n = RX_START;
                    end
                end
                // Eighth tick after the falling edge is mid start bit.
                RX_START: begin
                    if (rx_cnt == 4'd7) begin
                        rx_cnt_n = '0;
                        rx_bit_n = '0;
                        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_n = rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    rx_cnt_n = rx_cnt + 1'b1;
                    if (rx_cnt == 4'd15) begin
                        rx_shift_n = {rx_s, rx_shift[7:1]};
                        if (rx_bit == LAST_BIT) begin
                            rx_state_n = RX_STOP;
                        end else begin
                            rx_bit_n = rx_bit + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    rx_cnt_n = rx_cnt + 1'b1;
                    if (rx_cnt == 4'd15) begin
                        rx_load    = 1'b1;
                        rx_state_n = RX_IDLE;
`ifdef UART_FRAME_ERR_EN
                        rx_done = rx_s;
                        rx_ferr = !rx_s;
`else
                        rx_done = 1'b1;
`endif
                    end
                end
            endcase
        end
    end

    // Completion has priority over rdy_clr.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            if (rx_load) begin
                dout_q <= rx_shift;
            end
            if (rx_done) begin
                rdy_q <= 1'b1;
            end else if (host.rdy_clr) begin
                rdy_q <= 1'b0;
            end
        end
    end

    assign host.dout = dout_q;
    assign host.rdy  = rdy_q;

`ifdef UART_FRAME_ERR_EN
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= rx_ferr;
        end
    end

    assign host.frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart, scaled to 16 clocks per bit (RX tick every clock).
module tb_uart;

    localparam int unsigned BIT_CYC = 16;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    logic tx;
    logic rx;
    logic rx_drv  = 1'b1;
    logic loop_en = 1'b1;

    uart_if bus ();

    assign rx = loop_en ? tx : rx_drv;

    uart #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .host    (bus),
        .tx      (tx),
        .rx      (rx)
    );

    always #5 clk_50m = ~clk_50m;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    logic [7:0]  exp_q[$];
    logic        rdy_prev = 1'b0;

    always @(posedge clk_50m) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout, got no event expected event", name);
    endtask

    // Scoreboard: every rising rdy must match the oldest byte sent.
    always @(negedge clk_50m) begin
        if (bus.rdy && !rdy_prev) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rdy: got dout %0h expected no byte", bus.dout);
            end else begin
                check("rx_dout", bus.dout, exp_q.pop_front());
            end
        end
        rdy_prev = bus.rdy;
    end

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;   // [0]=start ... [9]=stop
        bit         inject;  // pulse wr_en with 8'h3C mid-frame
    } vec_t;

    vec_t vecs[5];

    // Sends d, samples tx at bit centres, measures tx_busy duration.
    task automatic send_frame(input logic [7:0] d, input bit inject,
                              output logic [9:0] got, output int unsigned busy_len);
        int unsigned t0;
        @(negedge clk_50m);
        bus.din   = d;
        bus.wr_en = 1'b1;
        @(posedge clk_50m);
        #1;
        t0 = cyc;
        bus.wr_en = 1'b0;
        if (inject) begin
            fork
                begin
                    repeat (50) @(negedge clk_50m);
                    bus.din   = 8'h3C;
                    bus.wr_en = 1'b1;
                    @(negedge clk_50m);
                    bus.wr_en = 1'b0;
                end
            join_none
        end
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? BIT_CYC / 2 : BIT_CYC) @(posedge clk_50m);
            #1;
            got[i] = tx;
        end
        for (int k = 0; k < 40 && bus.tx_busy; k++) begin
            @(posedge clk_50m);
            #1;
        end
        busy_len = cyc - t0;
    endtask

    task automatic check_busy(input int unsigned busy_len);
        n_vec++;
        if (busy_len < 10 * BIT_CYC - 1 || busy_len > 10 * BIT_CYC + 1) begin
            n_err++;
            $display("FAIL busy_len: got %0d expected %0d +-1", busy_len, 10 * BIT_CYC);
        end
    endtask

    task automatic wait_rdy(input string name, input bit clear);
        bit seen = 1'b0;
        for (int k = 0; k < 20 * BIT_CYC && !seen; k++) begin
            @(negedge clk_50m);
            seen = bus.rdy;
        end
        if (!seen) begin
            fail_now(name);
        end else if (clear) begin
            bus.rdy_clr = 1'b1;
            @(negedge clk_50m);
            bus.rdy_clr = 1'b0;
            @(negedge clk_50m);
            check("rdy_after_clr", bus.rdy, 1'b0);
        end
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop);
        @(negedge clk_50m);
        rx_drv = 1'b0;
        repeat (BIT_CYC) @(negedge clk_50m);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BIT_CYC) @(negedge clk_50m);
        end
        rx_drv = stop;
        repeat (BIT_CYC) @(negedge clk_50m);
        rx_drv = 1'b1;
        repeat (4) @(negedge clk_50m);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  got;
        int unsigned blen;
        bit          seen;
        int unsigned fe_cnt;

        vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
        vecs[1] = '{8'hC3, 10'b1110000110, 1'b1};
        vecs[2] = '{8'h00, 10'b1000000000, 1'b0};
        vecs[3] = '{8'hFF, 10'b1111111110, 1'b0};
        vecs[4] = '{8'h6E, 10'b1011011100, 1'b0};

        bus.din     = '0;
        bus.wr_en   = 1'b0;
        bus.rdy_clr = 1'b0;

        repeat (3) @(posedge clk_50m);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", bus.tx_busy, 1'b0);
        check("rst_rdy", bus.rdy, 1'b0);
        check("rst_dout", bus.dout, 8'h00);
`ifdef UART_FRAME_ERR_EN
        check("rst_frame_err", bus.frame_err, 1'b0);
`endif
        @(negedge clk_50m);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_50m);

        // Table: frame shape, busy length, loopback receive.
        for (int v = 0; v < 5; v++) begin
            exp_q.push_back(vecs[v].din);
            send_frame(vecs[v].din, vecs[v].inject, got, blen);
            check("tx_frame", got, vecs[v].frame);
            check_busy(blen);
            wait_rdy("vec_rdy", 1'b1);
            if (vecs[v].inject) begin
                repeat (2 * BIT_CYC) @(negedge clk_50m);
                check("no_second_frame", bus.tx_busy, 1'b0);
            end
        end

        // Loopback sweep of every byte value.
        for (int b = 0; b < 256; b++) begin
            logic [7:0] d;
            d = b[7:0];
            exp_q.push_back(d);
            send_frame(d, 1'b0, got, blen);
            check("sweep_frame", got, {1'b1, d, 1'b0});
            wait_rdy("sweep_rdy", 1'b1);
        end

        // Short low glitch on idle rx, then a valid frame.
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (5) @(negedge clk_50m);
        rx_drv = 1'b0;
        repeat (5) @(negedge clk_50m);
        rx_drv = 1'b1;
        repeat (3 * BIT_CYC) @(negedge clk_50m);
        check("glitch_rdy", bus.rdy, 1'b0);
        exp_q.push_back(8'h5A);
        drive_rx(8'h5A, 1'b1);
        wait_rdy("glitch_next_rdy", 1'b1);

        // rdy_clr held through a completion: set must win for that cycle.
        bus.rdy_clr = 1'b1;
        seen = 1'b0;
        exp_q.push_back(8'hE7);
        fork
            drive_rx(8'hE7, 1'b1);
            for (int k = 0; k < 12 * BIT_CYC; k++) begin
                @(negedge clk_50m);
                if (bus.rdy) seen = 1'b1;
            end
        join
        check("set_wins", seen, 1'b1);
        bus.rdy_clr = 1'b0;
        @(negedge clk_50m);
        check("set_wins_cleared", bus.rdy, 1'b0);

        // Mid-frame reset with rdy pending and tx low.
        loop_en = 1'b1;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, got, blen);
        wait_rdy("pre_reset_rdy", 1'b0);
        @(negedge clk_50m);
        bus.din   = 8'h3C;
        bus.wr_en = 1'b1;
        @(posedge clk_50m);
        #1;
        bus.wr_en = 1'b0;
        repeat (20) @(posedge clk_50m);
        #3;
        check("pre_reset_tx", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", bus.tx_busy, 1'b0);
        check("reset_rdy", bus.rdy, 1'b0);
        check("reset_dout", bus.dout, 8'h00);
        repeat (3) @(negedge clk_50m);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50m);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b0, got, blen);
        check("post_reset_frame", got, 10'b1100000010);
        check_busy(blen);
        wait_rdy("post_reset_rdy", 1'b1);

        // Stop bit sampled as 0.
        loop_en = 1'b0;
`ifdef UART_FRAME_ERR_EN
        seen   = 1'b0;
        fe_cnt = 0;
        fork
            drive_rx(8'h96, 1'b0);
            for (int k = 0; k < 12 * BIT_CYC; k++) begin
                @(negedge clk_50m);
                if (bus.rdy) seen = 1'b1;
                if (bus.frame_err) fe_cnt++;
            end
        join
        check("ferr_pulses", fe_cnt, 1);
        check("ferr_rdy", seen, 1'b0);
        check("ferr_dout", bus.dout, 8'h96);
`else
        fe_cnt = 0;
        exp_q.push_back(8'h96);
        drive_rx(8'h96, 1'b0);
        wait_rdy("bad_stop_rdy", 1'b1);
        check("bad_stop_dout", bus.dout + fe_cnt, 8'h96);
`endif

        repeat (BIT_CYC) @(negedge clk_50m);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
